knn_model_loader: RTL and testbench
===================================

// Module: knn_model_loader
// PURPOSE
//  Front-end and model store for the knn classifier. Accepts labelled training
//  points over a valid/ready write stream into a NPoints-entry register file,
//  and drives that file onto knn's points/classes inputs. Issues queries one at
//  a time: holds din stable, waits out knn's pipeline and samples dout.
//  Returns the class on a valid/ready response stream.
// PARAMETERS
//  NPoints       17  training entries; must match knn
//  Classes       2   number of classes; CW = $clog2(Classes)
//  LatencyCycles 2   register stages inside knn (2 when UseFFs=1, 0 when UseFFs=0)
//  Overwrite     0   1: writes when full replace the oldest entry (ring); 0: stall
// PORTS
//  clk_i       in   1          clock
//  rst_i       in   1          synchronous reset, active-high
//  clear_i     in   1          synchronous model flush
//  wr_valid_i  in   1          training write valid
//  wr_ready_o  out  1          training write ready
//  wr_point_i  in   32         {x[15:0], y[15:0]}
//  wr_class_i  in   CW         label
//  q_valid_i   in   1          query valid
//  q_ready_o   out  1          query ready
//  q_point_i   in   32         query point {x, y}
//  r_valid_o   out  1          result valid
//  r_ready_i   in   1          result ready
//  r_class_o   out  CW         classified label
//  points_o    out  32 x NPoints   to knn points
//  classes_o   out  CW x NPoints   to knn classes
//  din_o       out  32         to knn din
//  dout_i      in   CW         from knn dout
//  count_o     out  $clog2(NPoints+1)  valid entries
//  full_o      out  1          count_o == NPoints
// BEHAVIOUR
//  Reset (rst_i=1 at edge): FSM=IDLE; count_o, wr_ptr, points_o, classes_o,
//   din_o, r_class_o = 0; r_valid_o = 0. While rst_i=1: wr_ready_o = q_ready_o = 0.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: accept a query when q_valid_i && q_ready_o. Load din_o <= q_point_i
//   and set wait counter = 0. Go to WAIT.
//   WAIT: counter increments each cycle. At the edge ending WAIT cycle
//   LatencyCycles+1: r_class_o <= dout_i, r_valid_o <= 1, go to RESP.
//   Accept-to-r_valid_o latency = LatencyCycles+1 cycles (3 by default).
//   RESP: r_valid_o and r_class_o are held until r_ready_i. On the handshake
//   edge: r_valid_o <= 0, go to IDLE. No new query is accepted in that same cycle.
//  q_ready_o = (state==IDLE) && full_o && !clear_i && !rst_i. Queries are
//   never accepted on a partial model.
//  wr_ready_o = (state==IDLE) && (!full_o || Overwrite) && !clear_i && !rst_i
//   && !(q_valid_i && q_ready_o). A query wins over a simultaneous write, so the
//   model is frozen from query accept until RESP handshake.
//  Write accept: points_o[wr_ptr] <= wr_point_i, classes_o[wr_ptr] <= wr_class_i.
//   wr_ptr wraps from NPoints-1 to 0. count_o increments and saturates at NPoints.
//   With Overwrite=1 and full, the entry at wr_ptr (the oldest) is replaced.
//  din_o holds its last query value between queries.
//  clear_i (any state): count_o, wr_ptr, points_o, classes_o <= 0.
//   r_valid_o <= 0; FSM -> IDLE. An in-flight query or pending result is
//   discarded. clear_i beats a same-cycle write. rst_i beats clear_i.
//  Arithmetic: unsigned counters; no distance math in this block.
// TESTING
//  1 Reset, write 17 points (i,i) with class i%2; count_o 0->17, full_o=1,
//    wr_ready_o=0 (Overwrite=0), points_o[16]=0x0010_0010.
//  2 Full model, query 0x0003_0003 with knn attached (UseFFs=1): r_valid_o
//    rises exactly 3 cycles after accept; r_class_o matches knn majority.
//  3 Hold r_ready_i=0 for 5 cycles in RESP: r_valid_o/r_class_o stable,
//    q_ready_o=0, wr_ready_o=0; release -> IDLE the following cycle.
//  4 q_valid_i and wr_valid_i both high in IDLE while full, Overwrite=1: query
//    accepted, write stalled; write lands at wr_ptr=0 after RESP handshake.
//  5 clear_i asserted in WAIT cycle 2: r_valid_o never rises, count_o=0,
//    q_ready_o=0 until 17 new writes complete.
//  6 Query with count_o=16: q_ready_o=0 indefinitely; 17th write -> q_ready_o=1
//    the next cycle.

Source files
------------

// File: rtl/knn_model_loader.sv
// knn_model_loader: training-point store and query sequencer for the knn classifier.
// Training points arrive on a valid/ready write stream and are kept in a
// register file that drives knn's points/classes inputs directly. Queries are
// issued one at a time. The loader holds din stable, waits out knn's pipeline,
// samples dout and returns the class on a valid/ready response stream.
module knn_model_loader #(
  parameter int NPoints       = 17,
  parameter int Classes       = 2,
  parameter int LatencyCycles = 2,
  parameter bit Overwrite     = 1'b0,
  localparam int CW   = (Classes > 1) ? $clog2(Classes) : 1,
  localparam int CntW = $clog2(NPoints + 1),
  localparam int PtrW = (NPoints > 1) ? $clog2(NPoints) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [31:0]                  wr_point_i,
  input  logic [CW-1:0]                wr_class_i,
  input  logic                         q_valid_i,
  output logic                         q_ready_o,
  input  logic [31:0]                  q_point_i,
  output logic                         r_valid_o,
  input  logic                         r_ready_i,
  output logic [CW-1:0]                r_class_o,
  output logic [NPoints-1:0][31:0]     points_o,
  output logic [NPoints-1:0][CW-1:0]   classes_o,
  output logic [31:0]                  din_o,
  input  logic [CW-1:0]                dout_i,
  output logic [CntW-1:0]              count_o,
  output logic                         full_o
);

  localparam int WaitW = (LatencyCycles > 0) ? $clog2(LatencyCycles + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(LatencyCycles);
  localparam logic [CntW-1:0]  CountMax = CntW'(NPoints);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(NPoints - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                       state_q;
  logic [WaitW-1:0]             wait_q;
  logic [CntW-1:0]              count_q;
  logic [PtrW-1:0]              ptr_q;
  logic [NPoints-1:0][31:0]     points_q;
  logic [NPoints-1:0][CW-1:0]   classes_q;
  logic [31:0]                  din_q;
  logic [CW-1:0]                rclass_q;
  logic                         rvalid_q;

  logic full_d;
  logic q_fire_d;
  logic wr_fire_d;

  // Handshake qualification: queries need a complete model, and a query
  // always wins over a write so the model stays frozen while knn is busy.
  always_comb begin
    full_d     = (count_q == CountMax);
    q_ready_o  = (state_q == ST_IDLE) && full_d && !clear_i && !rst_i;
    q_fire_d   = q_valid_i && q_ready_o;
    wr_ready_o = (state_q == ST_IDLE) && (!full_d || Overwrite) && !clear_i && !rst_i
                 && !q_fire_d;
    wr_fire_d  = wr_valid_i && wr_ready_o;
  end

  // Model store and query sequencer; reset beats flush, flush beats everything else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      count_q   <= '0;
      ptr_q     <= '0;
      points_q  <= '0;
      classes_q <= '0;
      din_q     <= '0;
      rclass_q  <= '0;
      rvalid_q  <= 1'b0;
    end else if (clear_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      ptr_q     <= '0;
      points_q  <= '0;
      classes_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (q_fire_d) begin
            din_q   <= q_point_i;
            wait_q  <= '0;
            state_q <= ST_WAIT;
          end else if (wr_fire_d) begin
            points_q[ptr_q]  <= wr_point_i;
            classes_q[ptr_q] <= wr_class_i;
            ptr_q            <= (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
            if (count_q != CountMax) begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_q == WaitLast) begin
            rclass_q <= dout_i;
            rvalid_q <= 1'b1;
            state_q  <= ST_RESP;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (r_ready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign r_valid_o = rvalid_q;
  assign r_class_o = rclass_q;
  assign points_o  = points_q;
  assign classes_o = classes_q;
  assign din_o     = din_q;
  assign count_o   = count_q;
  assign full_o    = full_d;

endmodule

// File: tb/tb_knn_model_loader.sv
// tb_knn_model_loader: two loaders (stall-when-full and ring-overwrite) share one
// stimulus stream; each drives a behavioural knn stand-in (1-nearest-neighbour,
// Manhattan distance, two register stages). A transaction-level model tracks
// the expected store contents and response timing and is compared every cycle.
module tb_knn_model_loader;

  localparam int N       = 17;
  localparam int Classes = 2;
  localparam int Lat     = 2;
  localparam int CW      = (Classes > 1) ? $clog2(Classes) : 1;
  localparam int CntW    = $clog2(N + 1);
  localparam int WideW   = N * 32;

  logic clk = 1'b0;
  logic rst, clr, wv, qv, rr;
  logic [31:0]   wp, qp;
  logic [CW-1:0] wc;

  logic                     wrReady [2];
  logic                     qReady  [2];
  logic                     rValid  [2];
  logic [CW-1:0]            rClass  [2];
  logic [N-1:0][31:0]       pts     [2];
  logic [N-1:0][CW-1:0]     cls     [2];
  logic [31:0]              din     [2];
  logic [CW-1:0]            dout    [2];
  logic [CntW-1:0]          count   [2];
  logic                     full    [2];

  int nChecks = 0;
  int nFails  = 0;

  // Free-running clock
  always #5 clk = ~clk;

  knn_model_loader #(.NPoints(N), .Classes(Classes), .LatencyCycles(Lat), .Overwrite(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .wr_valid_i(wv), .wr_ready_o(wrReady[0]), .wr_point_i(wp), .wr_class_i(wc),
    .q_valid_i(qv), .q_ready_o(qReady[0]), .q_point_i(qp),
    .r_valid_o(rValid[0]), .r_ready_i(rr), .r_class_o(rClass[0]),
    .points_o(pts[0]), .classes_o(cls[0]), .din_o(din[0]), .dout_i(dout[0]),
    .count_o(count[0]), .full_o(full[0])
  );

  knn_model_loader #(.NPoints(N), .Classes(Classes), .LatencyCycles(Lat), .Overwrite(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .wr_valid_i(wv), .wr_ready_o(wrReady[1]), .wr_point_i(wp), .wr_class_i(wc),
    .q_valid_i(qv), .q_ready_o(qReady[1]), .q_point_i(qp),
    .r_valid_o(rValid[1]), .r_ready_i(rr), .r_class_o(rClass[1]),
    .points_o(pts[1]), .classes_o(cls[1]), .din_o(din[1]), .dout_i(dout[1]),
    .count_o(count[1]), .full_o(full[1])
  );

  function automatic int absDiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Class of the nearest stored point; ties go to the lowest index
  function automatic logic [CW-1:0] nearest(input logic [N-1:0][31:0] p,
                                            input logic [N-1:0][CW-1:0] c,
                                            input logic [31:0] q);
    int best;
    int bestD;
    int d;
    best  = 0;
    bestD = 32'h7fffffff;
    for (int i = 0; i < N; i++) begin
      d = absDiff(int'(p[i][31:16]), int'(q[31:16])) + absDiff(int'(p[i][15:0]), int'(q[15:0]));
      if (d < bestD) begin
        bestD = d;
        best  = i;
      end
    end
    return c[best];
  endfunction

  // knn stand-in: din passes two register stages before the classifier output
  logic [31:0] pipe1 [2];
  logic [31:0] pipe2 [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe1[k] <= din[k];
      pipe2[k] <= pipe1[k];
    end
  end
  assign dout[0] = nearest(pts[0], cls[0], pipe2[0]);
  assign dout[1] = nearest(pts[1], cls[1], pipe2[1]);

  // Reference model state
  bit                   modelValid = 1'b0;
  int                   mCount;
  int                   mPtr   [2];
  logic [N-1:0][31:0]   mPts   [2];
  logic [N-1:0][CW-1:0] mCls   [2];
  logic [31:0]          mDin;
  bit                   mBusy;
  int                   mWait;
  bit                   mRv;
  logic [CW-1:0]        mRclass [2];
  logic [CW-1:0]        mExp    [2];

  task automatic checkOutput(input string name, input int k,
                             input logic [WideW-1:0] act, input logic [WideW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s[%0d] actual=%0h required=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    bit idle;
    bit mFull;
    bit expQr;
    bit expWr;
    idle  = !mBusy && !mRv;
    mFull = (mCount == N);
    expQr = idle && mFull && !clr && !rst;
    for (int k = 0; k < 2; k++) begin
      expWr = idle && (!mFull || k == 1) && !clr && !rst && !(qv && expQr);
      checkOutput("q_ready", k, WideW'(qReady[k]), WideW'(expQr));
      checkOutput("wr_ready", k, WideW'(wrReady[k]), WideW'(expWr));
      checkOutput("r_valid", k, WideW'(rValid[k]), WideW'(mRv));
      checkOutput("r_class", k, WideW'(rClass[k]), WideW'(mRclass[k]));
      checkOutput("din", k, WideW'(din[k]), WideW'(mDin));
      checkOutput("count", k, WideW'(count[k]), WideW'(mCount));
      checkOutput("full", k, WideW'(full[k]), WideW'(mFull));
      checkOutput("points", k, WideW'(pts[k]), WideW'(mPts[k]));
      checkOutput("classes", k, WideW'(cls[k]), WideW'(mCls[k]));
    end
  endtask

  task automatic modelAdvance();
    bit idle;
    bit mFull;
    idle  = !mBusy && !mRv;
    mFull = (mCount == N);
    if (rst) begin
      mCount = 0; mDin = '0; mBusy = 0; mWait = 0; mRv = 0;
      for (int k = 0; k < 2; k++) begin
        mPtr[k] = 0; mPts[k] = '0; mCls[k] = '0; mRclass[k] = '0; mExp[k] = '0;
      end
      modelValid = 1'b1;
    end else if (clr) begin
      mCount = 0; mBusy = 0; mRv = 0;
      for (int k = 0; k < 2; k++) begin
        mPtr[k] = 0; mPts[k] = '0; mCls[k] = '0;
      end
    end else if (idle) begin
      if (qv && mFull) begin
        mBusy = 1; mWait = 0; mDin = qp;
        for (int k = 0; k < 2; k++) mExp[k] = nearest(mPts[k], mCls[k], qp);
      end else if (wv) begin
        for (int k = 0; k < 2; k++) begin
          if (!mFull || k == 1) begin
            mPts[k][mPtr[k]] = wp;
            mCls[k][mPtr[k]] = wc;
            mPtr[k] = (mPtr[k] + 1) % N;
          end
        end
        if (!mFull) mCount++;
      end
    end else if (mBusy) begin
      mWait++;
      if (mWait == Lat + 1) begin
        mBusy = 0; mRv = 1;
        for (int k = 0; k < 2; k++) mRclass[k] = mExp[k];
      end
    end else if (rr) begin
      mRv = 0;
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance it
  task automatic applyStimulus(input logic r, input logic c, input logic w,
                               input logic [31:0] wpt, input logic [CW-1:0] wcl,
                               input logic q, input logic [31:0] qpt, input logic rdy);
    rst = r; clr = c; wv = w; wp = wpt; wc = wcl; qv = q; qp = qpt; rr = rdy;
    #1;
    if (modelValid) compareAll();
    modelAdvance();
    @(negedge clk);
  endtask

  function automatic logic [31:0] randPoint();
    logic [15:0] x;
    logic [15:0] y;
    x = 16'($urandom_range(0, 255));
    y = 16'($urandom_range(0, 255));
    return {x, y};
  endfunction

  // Directed scenarios followed by a randomized run
  initial begin : stimulus
    int lat;
    logic [31:0] p;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("resetCount", 0, WideW'(count[0]), WideW'(0));
    checkOutput("resetRvalid", 0, WideW'(rValid[0]), WideW'(0));

    for (int i = 0; i < N; i++) begin
      p = {16'(i), 16'(i)};
      applyStimulus(0, 0, 1, p, CW'(i % 2), 0, 0, 0);
    end
    checkOutput("fillCount", 0, WideW'(count[0]), WideW'(17));
    checkOutput("fillFull", 0, WideW'(full[0]), WideW'(1));
    checkOutput("fillWrReady", 0, WideW'(wrReady[0]), WideW'(0));
    checkOutput("fillWrReadyRing", 1, WideW'(wrReady[1]), WideW'(1));
    checkOutput("point16", 0, WideW'(pts[0][16]), WideW'(32'h0010_0010));

    applyStimulus(0, 0, 1, 32'hABCD_1234, 1'b1, 1, 32'h0003_0003, 0);
    lat = 0;
    while (rValid[0] !== 1'b1 && lat < 10) begin
      applyStimulus(0, 0, 1, 32'hABCD_1234, 1'b1, 0, 0, 0);
      lat++;
    end
    checkOutput("latency", 0, WideW'(lat), WideW'(3));
    checkOutput("queryClass", 0, WideW'(rClass[0]), WideW'(1));
    checkOutput("queryClass", 1, WideW'(rClass[1]), WideW'(1));

    repeat (5) applyStimulus(0, 0, 1, 32'hABCD_1234, 1'b1, 1, 32'h0003_0003, 0);
    checkOutput("holdRvalid", 0, WideW'(rValid[0]), WideW'(1));
    checkOutput("holdQReady", 0, WideW'(qReady[0]), WideW'(0));
    checkOutput("holdWrReady", 1, WideW'(wrReady[1]), WideW'(0));
    applyStimulus(0, 0, 1, 32'hABCD_1234, 1'b1, 0, 0, 1);
    checkOutput("releaseRvalid", 0, WideW'(rValid[0]), WideW'(0));
    applyStimulus(0, 0, 1, 32'hABCD_1234, 1'b1, 0, 0, 0);
    checkOutput("ringWrite", 1, WideW'(pts[1][0]), WideW'(32'hABCD_1234));
    checkOutput("stallNoWrite", 0, WideW'(pts[0][0]), WideW'(0));

    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0005_0005, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("clearCount", 0, WideW'(count[0]), WideW'(0));
    checkOutput("clearRvalid", 1, WideW'(rValid[1]), WideW'(0));

    for (int i = 0; i < N - 1; i++) applyStimulus(0, 0, 1, randPoint(), CW'($urandom_range(0, Classes - 1)), 1, randPoint(), 1);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 1, randPoint(), 1);
    checkOutput("partialQReady", 0, WideW'(qReady[0]), WideW'(0));
    applyStimulus(0, 0, 1, randPoint(), CW'($urandom_range(0, Classes - 1)), 0, 0, 1);
    qv = 1'b1;
    #1;
    checkOutput("lastWriteQReady", 0, WideW'(qReady[0]), WideW'(1));

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 999) == 0, $urandom_range(0, 149) == 0,
                    $urandom_range(0, 9) < 6, randPoint(), CW'($urandom_range(0, Classes - 1)),
                    $urandom_range(0, 9) < 3, randPoint(), $urandom_range(0, 9) < 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
